// File: rtl/matmul_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Package  : matmul_pkg
// Purpose  : Definitions shared by the matmul APB requester and the slave
//            side: default bus widths, the requester state encoding and
//            helpers for deriving the strobe width and counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package matmul_pkg;

    // Default widths, kept identical on the requester and slave sides
    localparam int c_default_data_width = 8;
    localparam int c_default_bus_width  = 16;
    localparam int c_default_addr_width = 32;

    // APB requester state encoding
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;

    typedef logic [c_state_w-1:0] apb_state_t;

    // Number of byte-lane strobes on the bus
    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    // Counter width able to hold 0..timeout; never narrower than one bit
    function automatic int calc_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : apb_timeout_counter
// Purpose  : Counts ACCESS cycles in which the slave is not ready and flags
//            expiry once TIMEOUT_CYCLES such cycles have elapsed. With
//            TIMEOUT_CYCLES = 0 the counter is removed and never expires.
// Ports    : clk_i      - clock
//            rst_ni     - asynchronous active-low reset
//            i_clear    - return the count to zero
//            i_enable   - advance the count by one
//            o_expired  - count has reached TIMEOUT_CYCLES
// Revision : 1.0 - initial release
//==============================================================================
module apb_timeout_counter
    import matmul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam int                 c_cnt_w = calc_cnt_width(TIMEOUT_CYCLES);
            localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

            logic [c_cnt_w-1:0] r_count;

            // Saturates at the limit so the expired flag cannot wrap away
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != c_limit)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expired = (r_count == c_limit);
        end else begin : g_disabled
            logic w_unused;
            assign w_unused  = &{1'b0, clk_i, rst_ni, i_clear, i_enable};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule : apb_timeout_counter
`default_nettype wire

// File: rtl/apb_master_module.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : apb_master_module
// Purpose  : APB requester for the matmul accelerator. Each accepted
//            valid/ready command becomes one SETUP+ACCESS transfer; new
//            commands are held off while the accelerator is busy, a stalled
//            ACCESS is aborted after TIMEOUT_CYCLES, and the outcome is
//            returned as a one-cycle response pulse.
// Ports    : clk_i, rst_ni               - clock, async active-low reset
//            cmd_valid_i / cmd_ready_o   - command handshake
//            cmd_write_i, cmd_addr_i,
//            cmd_wdata_i, cmd_strb_i     - command payload
//            rsp_valid_o, rsp_rdata_o,
//            rsp_err_o                   - response (data/err held)
//            psel_o, penable_o, pwrite_o,
//            paddr_o, pwdata_o, pstrb_o  - APB request side
//            pready_i, pslverr_i,
//            prdata_i                    - APB completion side
//            busy_i                      - accelerator busy
// Revision : 1.0 - initial release
//==============================================================================
module apb_master_module
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH     = c_default_data_width,
    parameter int BUS_WIDTH      = c_default_bus_width,
    parameter int ADDR_WIDTH     = c_default_addr_width,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int HOLD_ON_BUSY   = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    // Command interface
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
    // Response interface
    output logic                            rsp_valid_o,
    output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    // APB requester
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    input  logic                            pready_i,
    input  logic                            pslverr_i,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    // Accelerator status
    input  logic                            busy_i
);

    localparam int c_max_dim = calc_max_dim(BUS_WIDTH, DATA_WIDTH);

    apb_state_t             r_state;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [BUS_WIDTH-1:0]   r_pwdata;
    logic [c_max_dim-1:0]   r_pstrb;
    logic                   r_rsp_valid;
    logic [BUS_WIDTH-1:0]   r_rsp_rdata;
    logic                   r_rsp_err;

    logic                   w_busy_block;
    logic                   w_cmd_ready;
    logic                   w_accept;
    logic                   w_in_access;
    logic                   w_timeout;

    // busy_i only matters while idle; an in-flight transfer ignores it
    assign w_busy_block = (HOLD_ON_BUSY != 0) && busy_i;
    assign w_cmd_ready  = (r_state == c_st_idle) && !w_busy_block;
    assign w_accept     = cmd_valid_i && w_cmd_ready;
    assign w_in_access  = (r_state == c_st_access);

    // Count only the not-ready ACCESS cycles; cleared everywhere else so
    // every ACCESS phase starts from zero
    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access && !pready_i),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_st_idle;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_paddr   <= cmd_addr_i;
                        r_pwdata  <= cmd_wdata_i;
                        r_pwrite  <= cmd_write_i;
                        // Reads never present byte strobes on the bus
                        r_pstrb   <= cmd_write_i ? cmd_strb_i : '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_st_setup;
                    end
                end

                c_st_setup: begin
                    r_penable <= 1'b1;
                    r_state   <= c_st_access;
                end

                c_st_access: begin
                    // pready is tested first so a completion in the expiry
                    // cycle is reported as a normal response
                    if (pready_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                        r_rsp_err   <= pslverr_i;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= c_st_idle;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end

                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_ready_o = w_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;

endmodule : apb_master_module
`default_nettype wire

// File: tb/tb_apb_master_module.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_apb_master_module
// Purpose  : Self-checking bench for apb_master_module. A driver issues
//            directed and random commands, a reference model predicts each
//            response (data, error, latency) into a scoreboard queue, a
//            behavioural APB slave with per-command wait states and errors
//            answers the bus, and a monitor pops and compares responses.
// Revision : 1.0 - initial release
//==============================================================================
module tb_apb_master_module;

    localparam int T = 16;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  s;
        int          w;
        bit          e;
    } plan_t;

    typedef struct {
        logic [15:0] rdata;
        bit          err;
        int          hs;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [15:0] cmd_wdata_i = '0;
    logic [1:0]  cmd_strb_i = '0;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o;
    logic [15:0] pwdata_o;
    logic [1:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic [15:0] prdata_i = '0;
    logic        busy_i = 1'b0;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [15:0] ref_mem [logic [31:0]];
    logic [15:0] slv_mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rnd_busy = 1'b0;

    apb_master_module #(
        .DATA_WIDTH     (8),
        .BUS_WIDTH      (16),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (T),
        .HOLD_ON_BUSY   (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .prdata_i    (prdata_i),
        .busy_i      (busy_i)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Random busy: changes just after the clock edge, stable when sampled
    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_busy) busy_i = ($urandom_range(0, 3) == 0);
    end

    // Never accept while busy
    initial forever begin
        @(negedge clk);
        if (rst_n && busy_i) chk("ready_while_busy", {31'b0, cmd_ready_o}, 32'h0);
    end

    // Behavioural APB slave: plan entries give wait states and error per transfer
    initial begin
        plan_t       p;
        int          k;
        bit          active;
        logic [31:0] sa;
        logic        sw;
        logic [15:0] sd;
        logic [1:0]  ss;
        bit          stable;
        active = 1'b0;
        k      = 0;
        p      = '{1'b0, 32'h0, 16'h0, 2'b0, 0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active    = 1'b0;
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
            end else if (psel_o && !penable_o) begin
                chk("setup_one_cycle", {31'b0, active}, 32'h0);
                chk("setup_has_command", {31'b0, plan_q.size() > 0}, 32'h1);
                if (plan_q.size() > 0) p = plan_q.pop_front();
                active    = 1'b1;
                k         = 0;
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
                chk("paddr", paddr_o, p.a);
                chk("pwrite", {31'b0, pwrite_o}, {31'b0, p.wr});
                chk("pstrb", {30'b0, pstrb_o}, p.wr ? {30'b0, p.s} : 32'h0);
                if (p.wr) chk("pwdata", {16'b0, pwdata_o}, {16'b0, p.d});
                sa = paddr_o; sw = pwrite_o; sd = pwdata_o; ss = pstrb_o;
            end else if (psel_o && penable_o) begin
                chk("access_after_setup", {31'b0, active}, 32'h1);
                stable = (paddr_o == sa) && (pwrite_o == sw) && (pwdata_o == sd) && (pstrb_o == ss);
                chk("apb_signals_stable", {31'b0, stable}, 32'h1);
                if (active && k == p.w) begin
                    pready_i  = 1'b1;
                    pslverr_i = p.e;
                    if (p.wr) begin
                        prdata_i = 16'($urandom);
                        if (!p.e) slv_mem[paddr_o] = merge(slv_mem.exists(paddr_o) ? slv_mem[paddr_o] : 16'h0,
                                                           pwdata_o, pstrb_o);
                    end else begin
                        prdata_i = slv_mem.exists(paddr_o) ? slv_mem[paddr_o] : 16'h0;
                    end
                    active = 1'b0;
                end else begin
                    pready_i  = 1'b0;
                    pslverr_i = 1'($urandom);
                    prdata_i  = 16'($urandom);
                    k++;
                end
            end else begin
                if (active) begin
                    // Transfer ended without pready: must be a timeout abort
                    chk("timeout_access_cycles", k, T + 1);
                    chk("timeout_was_due", {31'b0, p.w > T}, 32'h1);
                    active = 1'b0;
                end
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        logic [15:0] last_rd;
        logic        last_err;
        exp_t        x;
        last_rd  = '0;
        last_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_rd  = '0;
                last_err = 1'b0;
                chk("no_rsp_in_reset", {31'b0, rsp_valid_o}, 32'h0);
            end else if (rsp_valid_o) begin
                chk("rsp_expected", {31'b0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    chk("rsp_rdata", {16'b0, rsp_rdata_o}, {16'b0, x.rdata});
                    chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, x.err});
                    chk("rsp_latency", cyc - x.hs, x.lat);
                end
                last_rd  = rsp_rdata_o;
                last_err = rsp_err_o;
            end else begin
                chk("rsp_rdata_hold", {16'b0, rsp_rdata_o}, {16'b0, last_rd});
                chk("rsp_err_hold", {31'b0, rsp_err_o}, {31'b0, last_err});
            end
        end
    end

    // Issue one command; hold_busy>0 first holds it off with busy_i for that many cycles
    task automatic send(input bit wr, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, input int w, input bit e, input int hold_busy);
        plan_t p;
        exp_t  x;
        int    guard;
        @(negedge clk);
        cmd_write_i = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
        cmd_valid_i = 1'b1;
        if (hold_busy > 0) begin
            busy_i = 1'b1;
            #1;
            for (int i = 0; i < hold_busy; i++) begin
                chk("busy_blocks_ready", {31'b0, cmd_ready_o}, 32'h0);
                chk("busy_no_psel", {31'b0, psel_o}, 32'h0);
                @(negedge clk);
            end
            busy_i = 1'b0;
            #1;
            chk("ready_on_busy_fall", {31'b0, cmd_ready_o}, 32'h1);
        end
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready_o !== 1'b1) begin
            chk("cmd_accept_timeout", {31'b0, cmd_ready_o}, 32'h1);
            cmd_valid_i = 1'b0;
            return;
        end
        // Reference model: outcome decided by wait states vs. timeout budget
        p = '{wr, a, d, s, w, e};
        if (w > T) begin
            x.rdata = 16'h0;
            x.err   = 1'b1;
        end else if (wr) begin
            x.rdata = 16'h0;
            x.err   = e;
            if (!e) ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 16'h0, d, s);
        end else begin
            x.rdata = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
            x.err   = e;
        end
        x.hs  = cyc;
        x.lat = 3 + ((w > T) ? T : w);
        plan_q.push_back(p);
        exp_q.push_back(x);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_complete", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_psel", {31'b0, psel_o}, 32'h0);
        chk("rst_penable", {31'b0, penable_o}, 32'h0);
        chk("rst_pwrite", {31'b0, pwrite_o}, 32'h0);
        chk("rst_paddr", paddr_o, 32'h0);
        chk("rst_pwdata", {16'b0, pwdata_o}, 32'h0);
        chk("rst_pstrb", {30'b0, pstrb_o}, 32'h0);
        chk("rst_rsp_rdata", {16'b0, rsp_rdata_o}, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'h0);
        rst_n = 1'b1;
        #1 chk("ready_after_reset", {31'b0, cmd_ready_o}, 32'h1);
        busy_i = 1'b1;
        #1 chk("ready_follows_busy", {31'b0, cmd_ready_o}, 32'h0);
        busy_i = 1'b0;

        // ---------------- directed transfers ----------------
        send(1'b1, 32'h0,  16'h1234, 2'b11, 0, 1'b0, 0);   // zero-wait write
        drain();
        send(1'b1, 32'h20, 16'hBEEF, 2'b11, 0, 1'b0, 0);
        send(1'b0, 32'h20, 16'h0000, 2'b11, 2, 1'b0, 0);   // read, 2 wait states
        drain();
        send(1'b1, 32'h4,  16'h5A5A, 2'b01, 0, 1'b1, 0);   // slave error on write
        send(1'b0, 32'h4,  16'h0000, 2'b00, 1, 1'b0, 0);
        drain();
        send(1'b0, 32'h6,  16'h0000, 2'b00, 40, 1'b0, 0);  // timeout
        send(1'b1, 32'h6,  16'hCAFE, 2'b10, 1, 1'b0, 0);   // next command normal
        send(1'b0, 32'h6,  16'h0000, 2'b00, T, 1'b0, 0);   // pready in expiry cycle
        send(1'b1, 32'h8,  16'h7777, 2'b11, T + 1, 1'b0, 0);
        send(1'b0, 32'h8,  16'h0000, 2'b00, 0, 1'b0, 0);
        drain();

        // ---------------- busy gating ----------------
        send(1'b0, 32'h0, 16'h0000, 2'b00, 1, 1'b0, 4);
        busy_i = 1'b1;                                      // rises mid-transfer
        drain();
        busy_i = 1'b0;

        // ---------------- random traffic ----------------
        rnd_busy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            int r, w;
            r = $urandom_range(0, 9);
            if (r < 7)      w = $urandom_range(0, 3);
            else if (r < 9) w = $urandom_range(T - 1, T + 2);
            else            w = 0;
            send(1'($urandom), 32'($urandom_range(0, 7)) * 2, 16'($urandom), 2'($urandom),
                 w, ($urandom_range(0, 7) == 0), 0);
        end
        drain();
        rnd_busy = 1'b0;
        @(negedge clk);
        busy_i = 1'b0;

        // ---------------- reset during ACCESS ----------------
        send(1'b0, 32'h2, 16'h0000, 2'b00, 50, 1'b0, 0);
        g = 0;
        while (!(psel_o && penable_o) && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("reached_access", {31'b0, psel_o && penable_o}, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", {31'b0, psel_o}, 32'h0);
        chk("async_rst_penable", {31'b0, penable_o}, 32'h0);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_mid_reset", {31'b0, cmd_ready_o}, 32'h1);
        send(1'b0, 32'h20, 16'h0000, 2'b00, 0, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_master_module
`default_nettype wire
